// File: rtl/hack_run_ctrl.sv
// Boot/run sequencer for the Hack computer: streams a program into ROM while
// the CPU is held in reset, boots it, then gates execution with a clock enable
// until the cycle budget runs out or the @END / 0;JMP idiom is seen.
module hack_run_ctrl #(
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 16,
  parameter int MAX_CYCLES  = 1000,
  parameter int HALT_DETECT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] rom_wdata,
  output logic              cpu_reset,
  output logic              cpu_en,
  input  logic [ADDR_W-1:0] cpu_pc,
  input  logic              step_mode,
  input  logic              step,
  output logic              busy,
  output logic              done,
  output logic              loop_halt,
  output logic              load_full,
  output logic [ADDR_W:0]   load_count,
  output logic [31:0]       cycle_count
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_BOOT, S_RUN, S_DONE} state_t;

  localparam logic [31:0]   BUDGET_LAST = (MAX_CYCLES == 0) ? 32'd0 : 32'(MAX_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic              boot_cnt;
  logic [ADDR_W-1:0] p1, p2;
  logic [1:0]        hist_n;
  logic              match_q;

  logic accept, addr_end, run_en, hit, loop_stop, budget_stop;

  // Handshake, run enable and stop conditions
  always_comb begin
    accept      = in_valid & in_ready;
    addr_end    = &addr;
    run_en      = (state == S_RUN) && (step_mode ? step : 1'b1);
    hit         = (HALT_DETECT != 0) && run_en && (hist_n == 2'd2) && (cpu_pc == p2);
    loop_stop   = hit && match_q;
    budget_stop = (MAX_CYCLES != 0) && run_en && (cycle_count == BUDGET_LAST);
  end

  assign rom_we    = accept;
  assign rom_addr  = addr;
  assign rom_wdata = in_data;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    cpu_reset = 1'b1;
    cpu_en    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: if (load_start) state_nxt = S_LOAD;
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept && (in_last || addr_end)) state_nxt = S_BOOT;
      end
      S_BOOT: begin
        // enabled under reset so the CPU actually latches PC=0
        cpu_en = 1'b1;
        busy   = 1'b1;
        if (boot_cnt) state_nxt = S_RUN;
      end
      S_RUN: begin
        cpu_reset = 1'b0;
        cpu_en    = run_en;
        busy      = 1'b1;
        if (load_start)                    state_nxt = S_LOAD;
        else if (loop_stop || budget_stop) state_nxt = S_DONE;
      end
      S_DONE: begin
        // CPU left out of reset so RAM/PC can be inspected
        cpu_reset = 1'b0;
        done      = 1'b1;
        if (load_start) state_nxt = S_LOAD;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Load address/count, boot timer, cycle counter and PC history
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr        <= '0;
      load_count  <= '0;
      load_full   <= 1'b0;
      loop_halt   <= 1'b0;
      cycle_count <= '0;
      boot_cnt    <= 1'b0;
      p1          <= '0;
      p2          <= '0;
      hist_n      <= '0;
      match_q     <= 1'b0;
    end else begin
      if (state != S_LOAD && state_nxt == S_LOAD) begin
        addr       <= '0;
        load_count <= '0;
        load_full  <= 1'b0;
        loop_halt  <= 1'b0;
      end
      if (accept) begin
        // the last address is written once and never wraps back onto word 0
        if (!addr_end) addr <= addr + ADDR_ONE;
        load_count <= load_count + CNT_ONE;
        if (addr_end && !in_last) load_full <= 1'b1;
      end
      if (state == S_LOAD && state_nxt == S_BOOT) begin
        cycle_count <= '0;
        boot_cnt    <= 1'b0;
        hist_n      <= '0;
        match_q     <= 1'b0;
      end
      if (state == S_BOOT) boot_cnt <= 1'b1;
      if (run_en) begin
        if (cycle_count != '1) cycle_count <= cycle_count + 32'd1;
        p1      <= cpu_pc;
        p2      <= p1;
        if (hist_n != 2'd2) hist_n <= hist_n + 2'd1;
        match_q <= hit;
        if (loop_stop && !load_start) loop_halt <= 1'b1;
      end
    end
  end

endmodule
